// File: rtl/dct_zigzag_serializer_pkg.sv
// Shared types and constants for the DCT coefficient path: coefficient
// width, block size, the JPEG zigzag scan table and the serializer states.
package dct_pkg;

  localparam int COEF_W  = 11;
  localparam int BLOCK_N = 64;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } zz_state_t;

  // Zigzag position k -> row-major index inside the 8x8 block.
  localparam logic [5:0] ZIGZAG [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Map a zigzag position to the row-major bank address.
  function automatic logic [5:0] zz_addr(input logic [5:0] k);
    return ZIGZAG[k];
  endfunction

endpackage

// File: rtl/dct_zigzag_serializer_if.sv
// Serial coefficient stream: valid/ready handshake carrying one zigzag
// ordered coefficient per beat plus its position and an end-of-block marker.
interface dct_zigzag_serializer_if #(
  parameter int COEF_W = dct_pkg::COEF_W
);

  logic              out_valid;
  logic              out_ready;
  logic [COEF_W-1:0] out_data;
  logic [5:0]        out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/dct_zigzag_serializer_coef_bank.sv
// 64-entry coefficient register file: whole-block parallel load, one
// asynchronous read port addressed by row-major index.
module dct_coef_bank #(
  parameter int COEF_W = dct_pkg::COEF_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [dct_pkg::BLOCK_N*COEF_W-1:0] load_data,
  input  logic [5:0]                         rd_addr,
  output logic [COEF_W-1:0]                  rd_data
);

  logic [dct_pkg::BLOCK_N*COEF_W-1:0] bank_q;
  logic [dct_pkg::BLOCK_N*COEF_W-1:0] bank_d;

  // Next bank contents: replace the whole block on load, otherwise hold.
  always_comb begin
    bank_d = bank_q;
    if (load) begin
      bank_d = load_data;
    end else begin
      bank_d = bank_q;
    end
  end

  // Bank storage, cleared by reset so stale blocks never leak out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  // Read mux over the registered bank.
  always_comb begin
    rd_data = bank_q[rd_addr*COEF_W +: COEF_W];
  end

endmodule

// File: rtl/dct_zigzag_serializer.sv
// Captures a parallel 8x8 coefficient block and replays it as a 64-beat
// zigzag-ordered stream. A new block is accepted only when idle or on the
// cycle the final beat is taken; any other arrival is dropped and flagged.
module dct_zigzag_serializer #(
  parameter int COEF_W = dct_pkg::COEF_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [dct_pkg::BLOCK_N*COEF_W-1:0] coef_in,
  dct_zigzag_serializer_if.master            out_if,
  output logic                               busy,
  output logic                               overrun
);

  import dct_pkg::*;

  zz_state_t         state_q, state_d;
  logic [5:0]        k_q, k_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              load_s;
  logic              accept_s;
  logic              final_accept_s;
  logic [5:0]        rd_addr_s;
  logic [COEF_W-1:0] rd_data_s;

  dct_coef_bank #(.COEF_W(COEF_W)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (coef_in),
    .rd_addr   (rd_addr_s),
    .rd_data   (rd_data_s)
  );

  // Handshake decode; uses only the registered valid so the outputs stay
  // free of any combinational path from out_ready.
  always_comb begin
    accept_s       = out_valid_q & out_if.out_ready;
    final_accept_s = accept_s & (k_q == 6'd63);
    rd_addr_s      = zz_addr(k_q);
  end

  // Next-state, beat counter, capture and overrun decisions.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    load_s    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_s  = 1'b1;
          k_d     = 6'd0;
          state_d = SHIFT;
        end else begin
          k_d     = 6'd0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (final_accept_s) begin
          k_d = 6'd0;
          if (in_valid) begin
            load_s  = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept_s) begin
            k_d = k_q + 6'd1;
          end else begin
            k_d = k_q;
          end
          if (in_valid) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 6'd0;
      end
    endcase
    out_valid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT);
    out_last_d  = (state_d == SHIFT) && (k_d == 6'd63);
  end

  // State, counter and output flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= 6'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Drive the stream; data is forced to zero whenever no block is held.
  always_comb begin
    out_if.out_valid = out_valid_q;
    out_if.out_index = k_q;
    out_if.out_last  = out_last_q;
    busy             = busy_q;
    overrun          = overrun_q;
    if (out_valid_q) begin
      out_if.out_data = rd_data_s;
    end else begin
      out_if.out_data = '0;
    end
  end

endmodule
